mul_pipe_unit: RTL

Pipelined, parametrised RV M-extension multiplier: MUL, MULH, MULHSU and MULHU at configurable width and latency. Results pass through an ID-tagged output buffer, so the writeback stage can stall without losing results. Credit-based issue backpressure and a flush input are included. The unit sits beside the ALU and divider as a functional unit between issue and writeback.

---
 rtl/mul_pipe_unit_pkg.sv | 32 +++
 rtl/mul_pipe_unit_result_fifo.sv | 65 ++++++
 rtl/mul_pipe_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mul_pipe_unit_pkg.sv
// Shared types for the functional units between issue and writeback.
package cva5_types;

  // Multiply op select, encoded as funct3[1:0].
  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  // Instruction tag width used by the multiply pipeline entries.
  localparam int unsigned MUL_ID_WIDTH = 3;

  // Control that travels alongside the datapath through each multiply stage.
  typedef struct packed {
    logic [MUL_ID_WIDTH-1:0] id;
    mul_op_t                 op;
    logic                    valid;
  } mul_pipe_entry_t;

  // rs1 is treated as signed for every op except MULHU.
  function automatic logic mul_rs1_signed(input mul_op_t o);
    return (o != MUL_OP_MULHU);
  endfunction

  // rs2 is treated as signed only for MUL and MULH.
  function automatic logic mul_rs2_signed(input mul_op_t o);
    return (o == MUL_OP_MUL) || (o == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_pipe_unit_result_fifo.sv
// mul_result_fifo: small in-order result buffer with a combinationally visible head.
// The head reads as zero whenever the buffer is empty.
module mul_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  // DEPTH is a power of two, so pointers wrap naturally.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A flush in the same cycle dominates both push and pop.
  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & o_valid & ~i_flush;
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset because validity lives in r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined MUL/MULH/MULHSU/MULHU with a tagged, stallable result buffer.
// Issue is credit based: occupancy counts everything in the pipe plus the buffer,
// so the buffer can never overflow.
module mul_pipe_unit
  import cva5_types::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned ID_WIDTH  = MUL_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [1:0]          op,
  input  logic [ID_WIDTH-1:0] id,
  input  logic                flush,
  output logic                wb_done,
  output logic [XLEN-1:0]     wb_rd,
  output logic [ID_WIDTH-1:0] wb_id,
  input  logic                wb_ack
);

  localparam int unsigned OCC_W = $clog2(OUT_DEPTH + 1);

  // Extend an operand to XLEN+1 bits, sign or zero depending on the op.
  function automatic logic [XLEN:0] ext_op(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

  // Sign-extend an XLEN+1 operand to 2*XLEN; the low 2*XLEN product bits are all we keep.
  function automatic logic [2*XLEN-1:0] widen(input logic [XLEN:0] v);
    return {{(XLEN-1){v[XLEN]}}, v};
  endfunction

  // MUL takes the low half, every other op the high half.
  function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] p, input mul_op_t o);
    return (o == MUL_OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic [OCC_W-1:0]         r_occ;
  logic                     w_accept;
  logic                     w_pop;
  mul_op_t                  w_op;
  logic                     w_tail_valid;
  mul_op_t                  w_tail_op;
  logic [ID_WIDTH-1:0]      w_tail_id;
  logic [2*XLEN-1:0]        w_tail_prod;
  logic [XLEN+ID_WIDTH-1:0] w_fifo_data;

  assign w_op        = mul_op_t'(op);
  assign issue_ready = (r_occ < OCC_W'(OUT_DEPTH)) && !rst;
  assign w_accept    = issue_valid && issue_ready && !flush;
  assign w_pop       = wb_done && wb_ack;

  // Credit counter: accepts add, pops remove, flush and reset clear.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_pop) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_accept && w_pop) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  genvar gi;
  generate
    if (STAGES == 1) begin : g_comb
      // Single stage: the buffer itself is the only register level.
      assign w_tail_valid = w_accept;
      assign w_tail_op    = w_op;
      assign w_tail_id    = id;
      assign w_tail_prod  = widen(ext_op(rs1, mul_rs1_signed(w_op)))
                          * widen(ext_op(rs2, mul_rs2_signed(w_op)));
    end else begin : g_piped
      mul_pipe_entry_t   r_ent0;
      logic [XLEN:0]     r_a;
      logic [XLEN:0]     r_b;
      mul_pipe_entry_t   w_echain [STAGES-1];
      logic [2*XLEN-1:0] w_pchain [STAGES-1];

      // Stage 1 control: tag, op and valid of the accepted request.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_ent0 <= '0;
        end else begin
          r_ent0.valid <= w_accept;
          r_ent0.op    <= w_op;
          r_ent0.id    <= id;
        end
      end

      // Stage 1 operands, already extended for the requested signedness.
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_a <= ext_op(rs1, mul_rs1_signed(w_op));
          r_b <= ext_op(rs2, mul_rs2_signed(w_op));
        end
      end

      assign w_echain[0] = r_ent0;
      assign w_pchain[0] = widen(r_a) * widen(r_b);

      // Remaining stages only delay the product so synthesis can retime it into DSP registers.
      for (gi = 1; gi < STAGES - 1; gi++) begin : g_retime
        mul_pipe_entry_t   r_ent;
        logic [2*XLEN-1:0] r_prod;

        // Advance control one stage, dropping everything on flush.
        always_ff @(posedge clk) begin
          if (rst || flush) begin
            r_ent <= '0;
          end else begin
            r_ent <= w_echain[gi-1];
          end
        end

        // Advance the product one stage.
        always_ff @(posedge clk) begin
          r_prod <= w_pchain[gi-1];
        end

        assign w_echain[gi] = r_ent;
        assign w_pchain[gi] = r_prod;
      end

      assign w_tail_valid = w_echain[STAGES-2].valid;
      assign w_tail_op    = w_echain[STAGES-2].op;
      assign w_tail_id    = w_echain[STAGES-2].id;
      assign w_tail_prod  = w_pchain[STAGES-2];
    end
  endgenerate

  mul_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (XLEN + ID_WIDTH)
  ) u_result_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_tail_valid),
    .i_push_data ({w_tail_id, pick(w_tail_prod, w_tail_op)}),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_valid     (wb_done),
    .o_data      (w_fifo_data)
  );

  assign wb_id = w_fifo_data[XLEN+ID_WIDTH-1:XLEN];
  assign wb_rd = w_fifo_data[XLEN-1:0];

endmodule
